// File: rtl/instr_mem_responder_if.sv
// Fetch request / instruction response channel between the fetch unit
// and the instruction memory responder.
interface instr_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_err;

   modport master (
      output req_valid,
      output req_addr,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_instr,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_instr,
      output rsp_err
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: one fetch in flight, fixed latency,
// valid/ready response, independent program load port.
module instr_mem_responder #(
   parameter int  DEPTH   = 64,
   parameter int  LATENCY = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_mem_responder_if.slave bus,
   input  logic                 ld_en,
   input  logic [AW-1:0]        ld_addr,
   input  logic [31:0]          ld_data,
   output logic                 busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CW-1:0] CNT_LOAD =
      CW'((LATENCY >= 2) ? LATENCY - 2 : 0);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   instr_q, instr_d;
   logic          err_q, err_d;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_idx;
   logic          addr_err;
   logic          accept;

   assign rd_idx   = bus.req_addr[AW+1:2];
   assign addr_err = (bus.req_addr[1:0] != 2'b00) |
                     (bus.req_addr[31:2] >= 30'(DEPTH));

   // Held low during reset so nothing is accepted before release.
   assign bus.req_ready = rst & (state_q == IDLE);
   assign accept        = bus.req_valid & bus.req_ready;

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_instr = instr_q;
   assign bus.rsp_err   = err_q;
   assign busy          = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      instr_d = instr_q;
      err_d   = err_q;
      unique case (1'b1)
         (state_q == IDLE): begin
            if (accept) begin
               // mem read here sees pre-write contents on a load collision.
               instr_d = addr_err ? 32'h0 : mem[rd_idx];
               err_d   = addr_err;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         (state_q == WAIT): begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         (state_q == RESP): begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         instr_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: default build (LATENCY=2)
// plus a LATENCY=1 build sharing clock, reset and load port.
module tb_instr_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_en;
   logic [5:0]  ld_addr;
   logic [31:0] ld_data;
   logic        busy0;
   logic        busy1;

   int vec  = 0;
   int errs = 0;

   instr_mem_responder_if bus0 ();
   instr_mem_responder_if bus1 ();

   instr_mem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus0.slave),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .busy    (busy0)
   );

   instr_mem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus1.slave),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .busy    (busy1)
   );

   always #5 clk = ~clk;

   task automatic load(input logic [5:0] idx, input logic [31:0] d);
      ld_en   = 1'b1;
      ld_addr = idx;
      ld_data = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   // Drives one fetch with rsp_ready=1 and returns what was observed.
   task automatic do_fetch(input  logic [31:0] a,
                           output logic        r0,
                           output logic        v1,
                           output logic        v2,
                           output logic [31:0] ins,
                           output logic        er,
                           output logic        r3);
      bus0.req_addr  = a;
      bus0.req_valid = 1'b1;
      bus0.rsp_ready = 1'b1;
      r0 = bus0.req_ready;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      v1 = bus0.rsp_valid;
      @(negedge clk);
      v2  = bus0.rsp_valid;
      ins = bus0.rsp_instr;
      er  = bus0.rsp_err;
      @(negedge clk);
      r3 = bus0.req_ready;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ld_en = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      bus0.req_valid = 1'b0;
      bus0.req_addr  = '0;
      bus0.rsp_ready = 1'b0;
      bus1.req_valid = 1'b0;
      bus1.req_addr  = '0;
      bus1.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if (bus0.rsp_valid !== 1'b0) begin
         errs++; $display("FAIL rst_valid: got %b want 0", bus0.rsp_valid);
      end
      vec++;
      if (bus0.rsp_instr !== 32'h0) begin
         errs++; $display("FAIL rst_instr: got %h want 0", bus0.rsp_instr);
      end
      vec++;
      if (bus0.rsp_err !== 1'b0) begin
         errs++; $display("FAIL rst_err: got %b want 0", bus0.rsp_err);
      end
      vec++;
      if (busy0 !== 1'b0) begin
         errs++; $display("FAIL rst_busy: got %b want 0", busy0);
      end
      vec++;
      if (bus0.req_ready !== 1'b0) begin
         errs++; $display("FAIL rst_ready: got %b want 0", bus0.req_ready);
      end
      rst = 1'b1;
      #1;
      vec++;
      if (bus0.req_ready !== 1'b1) begin
         errs++; $display("FAIL rel_ready: got %b want 1", bus0.req_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [31:0] prog [4];
      logic        r0, v1, v2, er, r3;
      logic [31:0] ins;
      prog[0] = 32'h00000013;
      prog[1] = 32'h00500093;
      prog[2] = 32'h00A00113;
      prog[3] = 32'h002081B3;
      for (int i = 0; i < 4; i++) load(6'(i), prog[i]);
      load(6'd63, 32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         do_fetch(32'(i * 4), r0, v1, v2, ins, er, r3);
         vec++;
         if (r0 !== 1'b1) begin
            errs++; $display("FAIL basic_ready%0d: got %b want 1", i, r0);
         end
         vec++;
         if (v1 !== 1'b0) begin
            errs++; $display("FAIL basic_early%0d: got %b want 0", i, v1);
         end
         vec++;
         if (v2 !== 1'b1) begin
            errs++; $display("FAIL basic_valid%0d: got %b want 1", i, v2);
         end
         vec++;
         if (ins !== prog[i]) begin
            errs++; $display("FAIL basic_instr%0d: got %h want %h", i, ins, prog[i]);
         end
         vec++;
         if (er !== 1'b0) begin
            errs++; $display("FAIL basic_err%0d: got %b want 0", i, er);
         end
         vec++;
         if (r3 !== 1'b1) begin
            errs++; $display("FAIL basic_ret%0d: got %b want 1", i, r3);
         end
      end
   endtask

   task automatic test_backpressure();
      bus0.req_addr  = 32'h4;
      bus0.req_valid = 1'b1;
      bus0.rsp_ready = 1'b0;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         vec++;
         if (bus0.rsp_valid !== 1'b1 || bus0.rsp_instr !== 32'h00500093 ||
             bus0.rsp_err !== 1'b0 || bus0.req_ready !== 1'b0) begin
            errs++;
            $display("FAIL bp_hold%0d: got v=%b i=%h e=%b r=%b want v=1 i=00500093 e=0 r=0",
                     i, bus0.rsp_valid, bus0.rsp_instr, bus0.rsp_err, bus0.req_ready);
         end
         @(negedge clk);
      end
      bus0.rsp_ready = 1'b1;
      vec++;
      if (bus0.rsp_valid !== 1'b1) begin
         errs++; $display("FAIL bp_fifth: got %b want 1", bus0.rsp_valid);
      end
      @(negedge clk);
      vec++;
      if (bus0.rsp_valid !== 1'b0 || bus0.req_ready !== 1'b1) begin
         errs++;
         $display("FAIL bp_done: got v=%b r=%b want v=0 r=1",
                  bus0.rsp_valid, bus0.req_ready);
      end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [4];
      logic [31:0] exp_i [4];
      logic        exp_e [4];
      logic        r0, v1, v2, er, r3;
      logic [31:0] ins;
      addrs[0] = 32'h6;         exp_i[0] = 32'h0;         exp_e[0] = 1'b1;
      addrs[1] = 32'h100;       exp_i[1] = 32'h0;         exp_e[1] = 1'b1;
      addrs[2] = 32'hFC;        exp_i[2] = 32'hCAFE_F00D; exp_e[2] = 1'b0;
      addrs[3] = 32'h8000_0004; exp_i[3] = 32'h0;         exp_e[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_fetch(addrs[i], r0, v1, v2, ins, er, r3);
         vec++;
         if (v2 !== 1'b1 || er !== exp_e[i] || ins !== exp_i[i]) begin
            errs++;
            $display("FAIL err_%h: got v=%b e=%b i=%h want v=1 e=%b i=%h",
                     addrs[i], v2, er, ins, exp_e[i], exp_i[i]);
         end
      end
   endtask

   task automatic test_load_collision();
      logic        r0, v1, v2, er, r3;
      logic [31:0] ins;
      load(6'd2, 32'hAAAA_AAAA);
      bus0.req_addr  = 32'h8;
      bus0.req_valid = 1'b1;
      bus0.rsp_ready = 1'b1;
      ld_en   = 1'b1;
      ld_addr = 6'd2;
      ld_data = 32'h5555_5555;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      ld_en = 1'b0;
      @(negedge clk);
      vec++;
      if (bus0.rsp_valid !== 1'b1 || bus0.rsp_instr !== 32'hAAAA_AAAA) begin
         errs++;
         $display("FAIL coll_old: got v=%b i=%h want v=1 i=aaaaaaaa",
                  bus0.rsp_valid, bus0.rsp_instr);
      end
      @(negedge clk);
      do_fetch(32'h8, r0, v1, v2, ins, er, r3);
      vec++;
      if (ins !== 32'h5555_5555) begin
         errs++; $display("FAIL coll_new: got %h want 55555555", ins);
      end
   endtask

   task automatic test_reset_mid();
      logic        r0, v1, v2, er, r3;
      logic [31:0] ins;
      bus0.req_addr  = 32'hC;
      bus0.req_valid = 1'b1;
      bus0.rsp_ready = 1'b1;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      rst = 1'b0;
      #1;
      vec++;
      if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin
         errs++;
         $display("FAIL rmw_abort: got v=%b b=%b want 0 0", bus0.rsp_valid, busy0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vec++;
      if (bus0.req_ready !== 1'b1) begin
         errs++; $display("FAIL rmw_ready: got %b want 1", bus0.req_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++;
         if (bus0.rsp_valid !== 1'b0) begin
            errs++; $display("FAIL rmw_ghost%0d: got %b want 0", i, bus0.rsp_valid);
         end
      end
      bus0.rsp_ready = 1'b0;
      bus0.req_valid = 1'b1;
      @(negedge clk);
      bus0.req_valid = 1'b0;
      @(negedge clk);
      vec++;
      if (bus0.rsp_valid !== 1'b1) begin
         errs++; $display("FAIL rmr_inresp: got %b want 1", bus0.rsp_valid);
      end
      rst = 1'b0;
      #1;
      vec++;
      if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b0) begin
         errs++;
         $display("FAIL rmr_abort: got v=%b b=%b want 0 0", bus0.rsp_valid, busy0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      vec++;
      if (bus0.req_ready !== 1'b1) begin
         errs++; $display("FAIL rmr_ready: got %b want 1", bus0.req_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vec++;
         if (bus0.rsp_valid !== 1'b0) begin
            errs++; $display("FAIL rmr_ghost%0d: got %b want 0", i, bus0.rsp_valid);
         end
      end
      do_fetch(32'hC, r0, v1, v2, ins, er, r3);
      vec++;
      if (v2 !== 1'b1 || ins !== 32'h002081B3) begin
         errs++; $display("FAIL rm_intact: got v=%b i=%h want v=1 i=002081b3", v2, ins);
      end
   endtask

   task automatic test_latency1();
      bus1.req_addr  = 32'h4;
      bus1.req_valid = 1'b1;
      bus1.rsp_ready = 1'b1;
      vec++;
      if (bus1.req_ready !== 1'b1) begin
         errs++; $display("FAIL l1_ready: got %b want 1", bus1.req_ready);
      end
      @(negedge clk);
      bus1.req_valid = 1'b0;
      vec++;
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_instr !== 32'h00500093 ||
          bus1.rsp_err !== 1'b0) begin
         errs++;
         $display("FAIL l1_rsp: got v=%b i=%h e=%b want v=1 i=00500093 e=0",
                  bus1.rsp_valid, bus1.rsp_instr, bus1.rsp_err);
      end
      @(negedge clk);
      vec++;
      if (bus1.rsp_valid !== 1'b0 || bus1.req_ready !== 1'b1 || busy1 !== 1'b0) begin
         errs++;
         $display("FAIL l1_done: got v=%b r=%b b=%b want v=0 r=1 b=0",
                  bus1.rsp_valid, bus1.req_ready, busy1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_errors();
      test_load_collision();
      test_reset_mid();
      test_latency1();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
